// File: rtl/cache_pkg.sv
// Shared definitions for the cache fill arbiter: widths, memory timing,
// FSM state encoding and block-address helper.
package cache_pkg;

   localparam int ADDR_W        = 16;
   localparam int DATA_W        = 16;
   localparam int MEM_LAT       = 4;
   localparam int WORDS_PER_BLK = 8;
   localparam int WORD_W        = 3;

   localparam logic [ADDR_W-1:0] BLK_OFFSET_MASK = 16'hFFF0;

   localparam logic FILL_SEL_I = 1'b0;
   localparam logic FILL_SEL_D = 1'b1;

   typedef enum logic [2:0] {
      ST_FLUSH = 3'd0,
      ST_IDLE  = 3'd1,
      ST_WRITE = 3'd2,
      ST_ISSUE = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } arb_state_e;

   function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] addr);
      return addr & BLK_OFFSET_MASK;
   endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Cache-side and memory-side signals of the fill arbiter; master is the
// arbiter's view, slave is the view of the caches/memory around it.
interface cache_fill_arbiter_if;
   import cache_pkg::*;

   logic              i_miss;
   logic [ADDR_W-1:0] i_miss_addr;
   logic              d_miss;
   logic [ADDR_W-1:0] d_miss_addr;
   logic              d_wr_req;
   logic [ADDR_W-1:0] d_wr_addr;
   logic [DATA_W-1:0] d_wr_data;
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;
   logic              fill_we;
   logic              fill_sel;
   logic [WORD_W-1:0] fill_word;
   logic [DATA_W-1:0] fill_data;
   logic              fill_tag_we;
   logic              i_fill_done;
   logic              d_fill_done;
   logic              d_wr_ack;
   logic              busy;

   modport master (
      input  i_miss, i_miss_addr, d_miss, d_miss_addr,
      input  d_wr_req, d_wr_addr, d_wr_data,
      input  mem_rdata, mem_valid,
      output mem_en, mem_wr, mem_addr, mem_wdata,
      output fill_we, fill_sel, fill_word, fill_data, fill_tag_we,
      output i_fill_done, d_fill_done, d_wr_ack, busy
   );

   modport slave (
      output i_miss, i_miss_addr, d_miss, d_miss_addr,
      output d_wr_req, d_wr_addr, d_wr_data,
      output mem_rdata, mem_valid,
      input  mem_en, mem_wr, mem_addr, mem_wdata,
      input  fill_we, fill_sel, fill_word, fill_data, fill_tag_we,
      input  i_fill_done, d_fill_done, d_wr_ack, busy
   );

endinterface

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the single-ported pipelined memory between write-through stores,
// D-cache fills and I-cache fills, and sequences each 8-word block fill.
module cache_fill_arbiter
   import cache_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   cache_fill_arbiter_if.master bus
);

   localparam int                FLUSH_W    = $clog2(MEM_LAT + 1);
   localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(MEM_LAT - 1);
   localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(WORDS_PER_BLK - 1);

   arb_state_e         state_r;
   arb_state_e         state_nxt_s;
   logic [FLUSH_W-1:0] flush_cnt_r;
   logic [WORD_W-1:0]  issue_cnt_r;
   logic [WORD_W-1:0]  ret_cnt_r;
   logic [ADDR_W-1:0]  base_r;
   logic               fill_sel_r;
   logic               ret_fire_s;
   logic               ret_last_s;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_FLUSH;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Flush guard, issue/return counters and the block base latched at grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_cnt_r <= {FLUSH_W{1'b0}};
         issue_cnt_r <= {WORD_W{1'b0}};
         ret_cnt_r   <= {WORD_W{1'b0}};
         base_r      <= {ADDR_W{1'b0}};
         fill_sel_r  <= FILL_SEL_I;
      end else begin
         case (state_r)
            ST_FLUSH: begin
               if (flush_cnt_r == FLUSH_LAST) begin
                  flush_cnt_r <= {FLUSH_W{1'b0}};
               end else begin
                  flush_cnt_r <= flush_cnt_r + FLUSH_W'(1);
               end
            end
            ST_IDLE: begin
               // Stores take priority and do not disturb the fill context.
               if (!bus.d_wr_req && bus.d_miss) begin
                  base_r     <= blk_base(bus.d_miss_addr);
                  fill_sel_r <= FILL_SEL_D;
               end else if (!bus.d_wr_req && bus.i_miss) begin
                  base_r     <= blk_base(bus.i_miss_addr);
                  fill_sel_r <= FILL_SEL_I;
               end
            end
            ST_ISSUE: issue_cnt_r <= issue_cnt_r + WORD_W'(1);
            ST_DONE: begin
               issue_cnt_r <= {WORD_W{1'b0}};
               ret_cnt_r   <= {WORD_W{1'b0}};
            end
            default: ;
         endcase
         if (ret_fire_s) begin
            ret_cnt_r <= ret_cnt_r + WORD_W'(1);
         end
      end
   end

   // Next-state decode and all outputs; return path is live only while a fill is in flight.
   always_comb begin
      state_nxt_s     = state_r;
      ret_fire_s      = 1'b0;
      ret_last_s      = 1'b0;
      bus.mem_en      = 1'b0;
      bus.mem_wr      = 1'b0;
      bus.mem_addr    = {ADDR_W{1'b0}};
      bus.mem_wdata   = {DATA_W{1'b0}};
      bus.fill_we     = 1'b0;
      bus.fill_word   = {WORD_W{1'b0}};
      bus.fill_data   = {DATA_W{1'b0}};
      bus.fill_tag_we = 1'b0;
      bus.i_fill_done = 1'b0;
      bus.d_fill_done = 1'b0;
      bus.d_wr_ack    = 1'b0;
      bus.fill_sel    = fill_sel_r;
      // FLUSH is reset-like, so busy stays low there to keep every output 0 after reset.
      bus.busy        = (state_r != ST_IDLE) && (state_r != ST_FLUSH);

      if (((state_r == ST_ISSUE) || (state_r == ST_DRAIN)) && bus.mem_valid) begin
         ret_fire_s      = 1'b1;
         ret_last_s      = (ret_cnt_r == WORD_LAST);
         bus.fill_we     = 1'b1;
         bus.fill_word   = ret_cnt_r;
         bus.fill_data   = bus.mem_rdata;
         bus.fill_tag_we = (ret_cnt_r == WORD_LAST);
      end else begin
         ret_fire_s = 1'b0;
      end

      case (state_r)
         ST_FLUSH: begin
            if (flush_cnt_r == FLUSH_LAST) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_FLUSH;
            end
         end
         ST_IDLE: begin
            if (bus.d_wr_req) begin
               state_nxt_s = ST_WRITE;
            end else if (bus.d_miss || bus.i_miss) begin
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = bus.d_wr_addr;
            bus.mem_wdata = bus.d_wr_data;
            bus.d_wr_ack  = 1'b1;
            state_nxt_s   = ST_IDLE;
         end
         ST_ISSUE: begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = base_r | {{(ADDR_W-WORD_W-1){1'b0}}, issue_cnt_r, 1'b0};
            if (ret_last_s) begin
               state_nxt_s = ST_DONE;
            end else if (issue_cnt_r == WORD_LAST) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         ST_DRAIN: begin
            if (ret_last_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            bus.i_fill_done = (fill_sel_r == FILL_SEL_I);
            bus.d_fill_done = (fill_sel_r == FILL_SEL_D);
            state_nxt_s     = ST_IDLE;
         end
         default: state_nxt_s = ST_FLUSH;
      endcase
   end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a 4-cycle pipelined memory model.
module tb_cache_fill_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   cyc_no;

   logic [3:0]  pv;
   logic [15:0] pa [4];
   logic        inj_v;
   logic [15:0] inj_d;

   cache_fill_arbiter_if bus ();

   cache_fill_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: a read issued in cycle c returns addr ^ 16'h5A3C in cycle c+4.
   initial pv = 4'b0000;
   always @(posedge clk) begin
      pv    <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
      pa[0] <= bus.mem_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
   end
   assign bus.mem_valid = pv[3] | inj_v;
   assign bus.mem_rdata = inj_v ? inj_d : (pa[3] ^ 16'h5A3C);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc_no, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_no++;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, " mem_en"}, bus.mem_en, 1'b0);
      chk({tag, " busy"}, bus.busy, 1'b0);
      chk({tag, " fill_we"}, bus.fill_we, 1'b0);
      chk({tag, " tag_we"}, bus.fill_tag_we, 1'b0);
      chk({tag, " i_done"}, bus.i_fill_done, 1'b0);
      chk({tag, " d_done"}, bus.d_fill_done, 1'b0);
   endtask

   // Caller sits at grant cycle 0; checks cycles 1..last_k of the fill.
   task automatic check_fill(input logic [15:0] base, input logic sel, input int last_k);
      logic [15:0] a;
      for (int k = 1; k <= last_k; k++) begin
         cyc();
         if (k == 13) begin
            if (sel) bus.d_miss = 1'b0;
            else     bus.i_miss = 1'b0;
         end
         @(negedge clk);
         chk("busy", bus.busy, 1'b1);
         chk("fill_sel", bus.fill_sel, sel);
         if (k <= 8) begin
            a = base + 16'(2 * (k - 1));
            chk("mem_en", bus.mem_en, 1'b1);
            chk("mem_wr", bus.mem_wr, 1'b0);
            chk("mem_addr", bus.mem_addr, a);
         end else begin
            chk("mem_en idle", bus.mem_en, 1'b0);
         end
         if (k >= 5 && k <= 12) begin
            a = base + 16'(2 * (k - 5));
            chk("fill_we", bus.fill_we, 1'b1);
            chk("fill_word", bus.fill_word, 32'(k - 5));
            chk("fill_data", bus.fill_data, a ^ 16'h5A3C);
         end else begin
            chk("fill_we off", bus.fill_we, 1'b0);
         end
         chk("fill_tag_we", bus.fill_tag_we, (k == 12));
         chk("i_fill_done", bus.i_fill_done, (k == 13) && !sel);
         chk("d_fill_done", bus.d_fill_done, (k == 13) && sel);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc_no = 0;
      rst = 1'b1;
      inj_v = 1'b0;
      inj_d = 16'h0000;
      bus.i_miss = 1'b0;
      bus.i_miss_addr = 16'h0000;
      bus.d_miss = 1'b0;
      bus.d_miss_addr = 16'h0000;
      bus.d_wr_req = 1'b0;
      bus.d_wr_addr = 16'h0000;
      bus.d_wr_data = 16'h0000;

      // Reset state
      cyc();
      cyc();
      @(negedge clk);
      chk_quiet("reset");
      chk("reset mem_addr", bus.mem_addr, 16'h0000);
      chk("reset d_wr_ack", bus.d_wr_ack, 1'b0);
      chk("reset fill_sel", bus.fill_sel, 1'b0);

      // FLUSH holds 4 cycles and ignores the waiting I miss
      cyc();
      rst = 1'b0;
      bus.i_miss = 1'b1;
      bus.i_miss_addr = 16'h0126;
      @(negedge clk);
      chk_quiet("flush");
      for (int i = 0; i < 3; i++) begin
         cyc();
         @(negedge clk);
         chk_quiet("flush");
      end
      cyc();
      @(negedge clk);
      chk_quiet("grant0");
      check_fill(16'h0120, 1'b0, 13);

      // Simultaneous misses: D first, then I
      cyc();
      bus.i_miss_addr = 16'h0040;
      bus.i_miss = 1'b1;
      bus.d_miss_addr = 16'h8000;
      bus.d_miss = 1'b1;
      @(negedge clk);
      chk_quiet("grant dual");
      check_fill(16'h8000, 1'b1, 13);
      cyc();
      @(negedge clk);
      chk_quiet("grant i after d");
      check_fill(16'h0040, 1'b0, 13);

      // Store beats a simultaneous D miss
      cyc();
      bus.d_wr_req = 1'b1;
      bus.d_wr_addr = 16'h2002;
      bus.d_wr_data = 16'hBEEF;
      bus.d_miss = 1'b1;
      bus.d_miss_addr = 16'h3000;
      @(negedge clk);
      chk_quiet("grant wr");
      cyc();
      @(negedge clk);
      chk("wr mem_en", bus.mem_en, 1'b1);
      chk("wr mem_wr", bus.mem_wr, 1'b1);
      chk("wr mem_addr", bus.mem_addr, 16'h2002);
      chk("wr mem_wdata", bus.mem_wdata, 16'hBEEF);
      chk("wr d_wr_ack", bus.d_wr_ack, 1'b1);
      chk("wr busy", bus.busy, 1'b1);
      cyc();
      bus.d_wr_req = 1'b0;
      @(negedge clk);
      chk("post wr ack", bus.d_wr_ack, 1'b0);
      chk_quiet("grant d after wr");
      check_fill(16'h3000, 1'b1, 13);

      // Top-of-memory block does not wrap
      cyc();
      bus.d_miss_addr = 16'hFFFA;
      bus.d_miss = 1'b1;
      @(negedge clk);
      chk_quiet("grant top");
      check_fill(16'hFFF0, 1'b1, 13);

      // Stray mem_valid in IDLE
      cyc();
      inj_v = 1'b1;
      inj_d = 16'h1234;
      @(negedge clk);
      chk_quiet("idle stray");
      cyc();
      inj_v = 1'b0;
      @(negedge clk);
      chk_quiet("idle after stray");

      // Reset mid-fill at cycle 6, stale returns in FLUSH, then refill
      cyc();
      bus.i_miss_addr = 16'h0500;
      bus.i_miss = 1'b1;
      @(negedge clk);
      chk_quiet("grant abort");
      check_fill(16'h0500, 1'b0, 6);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk_quiet("abort flush");
      chk("abort mem_addr", bus.mem_addr, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         cyc();
         @(negedge clk);
         chk_quiet("abort flush");
      end
      cyc();
      @(negedge clk);
      chk_quiet("grant refill");
      check_fill(16'h0500, 1'b0, 13);

      cyc();
      @(negedge clk);
      chk_quiet("final idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
